dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter that shares one single-port 32x16 data memory between two requesters (e.g. CPU load/store unit and a DMA/debug port).
- Uses a valid/grant handshake per port and registers the winning access toward the memory.
- Returns read data one cycle after the memory access, with a valid pulse.
- Sits between the requesters and the data memory. The memory writes on the falling clock edge and reads combinationally.

Parameters:
- AW, 5, memory address width.
- DW, 16, memory data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_i  input  1  port 0 access request.
- we0_i  input  1  port 0 write enable (1 = write, 0 = read).
- addr0_i  input  AW  port 0 address.
- data0_i  input  DW  port 0 write data.
- gnt0_o  output  1  port 0 grant; combinational, same cycle as the request.
- data0_o  output  DW  port 0 read data, registered.
- vld0_o  output  1  port 0 read-data valid pulse.
- req1_i, we1_i, addr1_i, data1_i, gnt1_o, data1_o, vld1_o: same as port 0, for port 1.
- mem_Addr_o  output  AW  address to memory, registered.
- mem_data_o  output  DW  write data to memory, registered.
- mem_WEn_o  output  1  write enable to memory.
- mem_data_i  input  DW  combinational read data from memory.

Behaviour:
- Handshake:
  - A transfer on port x occurs in any cycle where req_x and gnt_x are both high.
  - The requester holds we/addr/data stable while req is high and gnt is low.
  - The requester may present the next access in the cycle after gnt.
- Grant logic (combinational):
  - Only one request: grant it.
  - Both request: round-robin; grant the port not granted last.
  - last_gnt register updates only on a transfer; reset value = 1, so port 0 wins the first conflict.
  - Both gnt outputs are forced to 0 while rst = 1.
- Pipeline, transfer in cycle N:
  - Rising edge ending N: capture addr/data/we/port-id into mem_Addr_o, mem_data_o, we_q, pid_q; set busy_q = 1.
  - Cycle N+1: memory access. A write commits on the falling edge inside N+1. A read is sampled at the rising edge ending N+1.
  - Cycle N+2 (reads only): data_pid_o = sampled mem_data_i; vld_pid_o = 1 for exactly one cycle.
  - data_x_o holds its value until the next read completes on that port. Writes produce no vld pulse.
- Throughput: one access per cycle, back to back. No transfer in cycle N gives busy_q = 0 and we_q = 0 in cycle N+1.
- mem_WEn_o = we_q & busy_q & ~rst. This gating means no memory write occurs in any cycle where rst is high.
- Ordering:
  - Accesses reach memory in grant order.
  - A write granted in cycle N is visible to any read granted in cycle N+1 or later, from either port.
- Idle: mem_Addr_o and mem_data_o hold their last value; mem_WEn_o = 0.
- Reset (synchronous):
  - mem_Addr_o = 0, mem_data_o = 0, we_q = 0, busy_q = 0.
  - data0_o = data1_o = 0, vld0_o = vld1_o = 0, last_gnt = 1.
  - An in-flight read is dropped (no vld pulse). An in-flight write is suppressed if rst is high during its memory cycle.
- Request deasserted before grant: it is withdrawn; no side effect.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins a conflict; last_gnt is not implemented.
- Undefined: round-robin as described above.

Test Plan:
- Port 0 writes addr 3 = 16'hBEEF, then reads addr 3 -> gnt0_o high in the request cycle; mem_WEn_o = 1 one cycle later; read gives vld0_o pulse with data0_o = 16'hBEEF two cycles after its grant.
- Both ports request every cycle; port 0 reads addr 1, port 1 reads addr 2 (preloaded 16'h0001 / 16'h0002) -> grants alternate 0,1,0,1 starting with port 0; vld pulses alternate with the correct data.
- Port 0 writes addr 5 = 16'h1234 in cycle N; port 1 reads addr 5 in cycle N+1 -> data1_o = 16'h1234.
- Port 1 holds a request while port 0 is granted -> port 1 addr/we/data unchanged until gnt1_o; exactly one memory access per transfer.
- Write to addr 7 granted, rst asserted in the following cycle -> mem_WEn_o stays 0 and addr 7 is unchanged. Read granted, then rst -> no vld pulse. All outputs return to reset values.
- With DMEM_ARB_FIXED_PRIO_EN defined and both ports requesting continuously -> port 0 is granted every cycle; port 1 is granted only after req0_i drops.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port data memory
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (port 0 always wins a conflict).
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] data0_i,
  output logic          gnt0_o,
  output logic [DW-1:0] data0_o,
  output logic          vld0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] data1_i,
  output logic          gnt1_o,
  output logic [DW-1:0] data1_o,
  output logic          vld1_o,
  output logic [AW-1:0] mem_Addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_WEn_o,
  input  logic [DW-1:0] mem_data_i
);

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          pid_q, pid_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic          vld0_q, vld0_d, vld1_q, vld1_d;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: port 0 wins every conflict; no grant history is kept.
  always_comb begin
    gnt0_o = req0_i & ~rst;
    gnt1_o = req1_i & ~req0_i & ~rst;
  end
`else
  logic last_gnt_q, last_gnt_d;

  // Round-robin: on a conflict the port that was not granted last wins.
  always_comb begin
    gnt0_o     = req0_i & (~req1_i | last_gnt_q) & ~rst;
    gnt1_o     = req1_i & (~req0_i | ~last_gnt_q) & ~rst;
    last_gnt_d = last_gnt_q;
    if (gnt0_o) begin
      last_gnt_d = 1'b0;
    end else if (gnt1_o) begin
      last_gnt_d = 1'b1;
    end
  end

  // Grant history only moves on a transfer; reset favours port 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Request stage: latch the winning access; address/data hold when idle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    we_d       = 1'b0;
    busy_d     = 1'b0;
    pid_d      = pid_q;
    if (gnt0_o) begin
      mem_addr_d = addr0_i;
      mem_data_d = data0_i;
      we_d       = we0_i;
      busy_d     = 1'b1;
      pid_d      = 1'b0;
    end else if (gnt1_o) begin
      mem_addr_d = addr1_i;
      mem_data_d = data1_i;
      we_d       = we1_i;
      busy_d     = 1'b1;
      pid_d      = 1'b1;
    end
  end

  // Response stage: sample memory read data at the end of the access cycle.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    vld0_d  = 1'b0;
    vld1_d  = 1'b0;
    if (busy_q && !we_q) begin
      if (pid_q) begin
        data1_d = mem_data_i;
        vld1_d  = 1'b1;
      end else begin
        data0_d = mem_data_i;
        vld0_d  = 1'b1;
      end
    end
  end

  // Pipeline registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_data_q <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      pid_q      <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      pid_q      <= pid_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
    end
  end

  // Reset gating keeps an in-flight write from committing during reset.
  assign mem_WEn_o  = we_q & busy_q & ~rst;
  assign mem_Addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign data0_o    = data0_q;
  assign data1_o    = data1_q;
  assign vld0_o     = vld0_q;
  assign vld1_o     = vld1_q;

endmodule
